// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if: timebase, demand inputs and light-head outputs of the phase scheduler.
// Carries ped_req/walk only when PED_WALK_EN is defined.
interface traffic_phase_scheduler_if;
   logic       tick;
   logic       ns_req;
   logic       ew_req;
   logic [2:0] ns_lights;
   logic [2:0] ew_lights;
   logic [2:0] phase;
`ifdef PED_WALK_EN
   logic       ped_req;
   logic       walk;
   modport master (output tick, ns_req, ew_req, ped_req, input ns_lights, ew_lights, phase, walk);
   modport slave  (input tick, ns_req, ew_req, ped_req, output ns_lights, ew_lights, phase, walk);
`else
   modport master (output tick, ns_req, ew_req, input ns_lights, ew_lights, phase);
   modport slave  (input tick, ns_req, ew_req, output ns_lights, ew_lights, phase);
`endif
endinterface

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: Moore sequencer for an NS/EW intersection with tick-based dwells,
// sticky demand latches and all-red clearance; PED_WALK_EN adds a pedestrian walk phase after AR2.
module traffic_phase_scheduler #(
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 2,
   parameter int ALLRED_CYC = 1,
   parameter int WALK_CYC   = 4,
   parameter int CNT_W      = 8
) (
   input logic clk,
   input logic reset,
   traffic_phase_scheduler_if.slave bus
);
   localparam logic [2:0] RED = 3'b100, GRN = 3'b101, YEL = 3'b001;
   typedef enum logic [2:0] {NS_G = 3'd0, NS_Y = 3'd1, AR1 = 3'd2, EW_G = 3'd3,
                             EW_Y = 3'd4, AR2 = 3'd5, WALK = 3'd6} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d, dur;
   logic             ns_pend_q, ns_pend_d, ew_pend_q, ew_pend_d, expire;
`ifdef PED_WALK_EN
   logic             ped_pend_q, ped_pend_d;
`endif
   always_comb begin
      case (state_q)
         NS_G, EW_G: dur = CNT_W'(GREEN_CYC);
         NS_Y, EW_Y: dur = CNT_W'(YELLOW_CYC);
         WALK:       dur = CNT_W'(WALK_CYC);
         default:    dur = CNT_W'(ALLRED_CYC);
      endcase
      expire  = bus.tick && (timer_q == dur - 1'b1);
      state_d = state_q;
      case (state_q)
         NS_G: if (expire && ew_pend_q) state_d = NS_Y;
         NS_Y: if (expire) state_d = AR1;
         AR1:  if (expire) state_d = EW_G;
         EW_G: if (expire && ns_pend_q) state_d = EW_Y;
         EW_Y: if (expire) state_d = AR2;
`ifdef PED_WALK_EN
         AR2:  if (expire) state_d = ped_pend_q ? WALK : NS_G;
         WALK: if (expire) state_d = NS_G;
`else
         AR2:  if (expire) state_d = NS_G;
`endif
         default: state_d = AR2;
      endcase
      // Expiry restarts the dwell even when the green is extended in place.
      timer_d   = (expire || state_d != state_q) ? '0 : timer_q + CNT_W'(bus.tick);
      ns_pend_d = (ns_pend_q | bus.ns_req) & ~(state_d == NS_G && state_q != NS_G);
      ew_pend_d = (ew_pend_q | bus.ew_req) & ~(state_d == EW_G && state_q != EW_G);
`ifdef PED_WALK_EN
      ped_pend_d = (ped_pend_q | bus.ped_req) & ~(state_d == WALK && state_q != WALK);
`endif
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= AR2;
         timer_q    <= '0;
         ns_pend_q  <= 1'b0;
         ew_pend_q  <= 1'b0;
`ifdef PED_WALK_EN
         ped_pend_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         ns_pend_q  <= ns_pend_d;
         ew_pend_q  <= ew_pend_d;
`ifdef PED_WALK_EN
         ped_pend_q <= ped_pend_d;
`endif
      end
   end
   assign bus.ns_lights = state_q == NS_G ? GRN : state_q == NS_Y ? YEL : RED;
   assign bus.ew_lights = state_q == EW_G ? GRN : state_q == EW_Y ? YEL : RED;
   assign bus.phase     = state_q;
`ifdef PED_WALK_EN
   assign bus.walk      = state_q == WALK;
`endif
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: scoreboard bench; a countdown reference model predicts lights/phase
// every cycle and the DUT outputs are compared one cycle-sample at a time.
module tb_traffic_phase_scheduler;
   localparam int G = 8, Y = 2, A = 1, W = 4;
`ifdef PED_WALK_EN
   localparam bit PED = 1'b1;
`else
   localparam bit PED = 1'b0;
`endif
   localparam logic [2:0] RED = 3'b100;
   logic clk = 1'b0, reset = 1'b1;
   int n_cmp = 0, n_err = 0;
   int m_ph, m_left;
   bit m_nsp, m_ewp, m_pp;
   logic [15:0] exp_q[$];
   traffic_phase_scheduler_if bus ();
   traffic_phase_scheduler #(.GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .WALK_CYC(W), .CNT_W(8))
      dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, want);
      end
   endtask
   function automatic int dur_of(input int ph);
      return (ph == 0 || ph == 3) ? G : (ph == 1 || ph == 4) ? Y : ph == 6 ? W : A;
   endfunction
   function automatic logic [2:0] head(input int ph, input bit ns);
      if (ph == (ns ? 0 : 3)) return 3'b101;
      if (ph == (ns ? 1 : 4)) return 3'b001;
      return RED;
   endfunction
   function automatic logic [15:0] model_out();
      return {6'b0, head(m_ph, 1'b1), head(m_ph, 1'b0), 3'(m_ph), m_ph == 6};
   endfunction
   function automatic logic [15:0] dut_out();
`ifdef PED_WALK_EN
      return {6'b0, bus.ns_lights, bus.ew_lights, bus.phase, bus.walk};
`else
      return {6'b0, bus.ns_lights, bus.ew_lights, bus.phase, 1'b0};
`endif
   endfunction
   task automatic model_step(input bit t, input bit n, input bit e, input bit p);
      int nxt;
      if (reset) begin
         m_ph = 5; m_left = A; m_nsp = 0; m_ewp = 0; m_pp = 0;
         return;
      end
      nxt = m_ph;
      if (t) begin
         if (m_left > 1) m_left--;
         else begin
            case (m_ph)
               0: nxt = m_ewp ? 1 : 0;
               1: nxt = 2;
               2: nxt = 3;
               3: nxt = m_nsp ? 4 : 3;
               4: nxt = 5;
               5: nxt = (PED && m_pp) ? 6 : 0;
               default: nxt = 0;
            endcase
            m_left = dur_of(nxt);
         end
      end
      m_nsp = (m_nsp | n) && !(nxt == 0 && m_ph != 0);
      m_ewp = (m_ewp | e) && !(nxt == 3 && m_ph != 3);
      m_pp  = PED && (m_pp | p) && !(nxt == 6 && m_ph != 6);
      m_ph  = nxt;
   endtask
   task automatic step(input bit t, input bit n, input bit e, input bit p);
      logic [15:0] got;
      bus.tick = t; bus.ns_req = n; bus.ew_req = e;
`ifdef PED_WALK_EN
      bus.ped_req = p;
`endif
      @(posedge clk);
      model_step(t, n, e, p);
      exp_q.push_back(model_out());
      #1;
      got = dut_out();
      chk("cycle", got, exp_q.pop_front());
      chk("excl", {15'b0, bus.ns_lights != RED && bus.ew_lights != RED}, 16'h0);
   endtask
   initial begin
      bus.tick = 0; bus.ns_req = 0; bus.ew_req = 0;
`ifdef PED_WALK_EN
      bus.ped_req = 0;
`endif
      model_step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      chk("reset_phase", {13'b0, bus.phase}, 16'd5);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) step(1, 0, i == 3, 0);
      chk("ew_green", {13'b0, bus.ew_lights}, 16'h5);
      reset = 1'b1;
      step(1, 0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
      chk("ns_hold", {13'b0, bus.ns_lights}, 16'h5);
      for (int i = 0; i < 120; i++) step(i % 3 == 0, 1, i == 1, 0);
      for (int i = 0; i < 150 && m_ph != 4; i++) step(1, 0, 1, 0);
      chk("reach_ewy", {13'b0, bus.phase}, 16'd4);
      #2 reset = 1'b1;
      #1;
      chk("async_ns", {13'b0, bus.ns_lights}, {13'b0, RED});
      chk("async_ew", {13'b0, bus.ew_lights}, {13'b0, RED});
      chk("async_ph", {13'b0, bus.phase}, 16'd5);
      model_step(0, 0, 0, 0);
      step(1, 1, 1, 1);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
`ifdef PED_WALK_EN
      for (int i = 0; i < 150 && m_ph != 3; i++) step(1, 0, 1, 0);
      step(1, 1, 0, 1);
      for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
`endif
      for (int i = 0; i < 400; i++)
         step($urandom_range(1, 0) == 1, $urandom_range(9, 0) == 0,
              $urandom_range(9, 0) == 0, $urandom_range(14, 0) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
